// File: rtl/alu_defs_pkg.sv
// Shared definitions for the bitwise ALU: operation codes and FSM state encodings.
package alu_defs;

  typedef enum logic [2:0] {
    ALU_AND   = 3'b000,
    ALU_OR    = 3'b001,
    ALU_XOR   = 3'b010,
    ALU_NAND  = 3'b011,
    ALU_NOR   = 3'b100,
    ALU_XNOR  = 3'b101,
    ALU_PASSA = 3'b110,
    ALU_NOTA  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

endpackage

// File: rtl/alu_bitwise_slice.sv
// Combinational SLICE-wide bitwise op unit with per-slice zero and parity flags.
module alu_bitwise_slice
  import alu_defs::*;
#(
  parameter int unsigned SLICE = 8
) (
  input  logic [2:0]       op,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic [SLICE-1:0] y,
  output logic             slice_zero,
  output logic             slice_parity
);

  always_comb begin
    y = '0;
    case (alu_op_e'(op))
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_XOR:   y = a ^ b;
      ALU_NAND:  y = ~(a & b);
      ALU_NOR:   y = ~(a | b);
      ALU_XNOR:  y = ~(a ^ b);
      ALU_PASSA: y = a;
      ALU_NOTA:  y = ~a;
      default:   y = '0;
    endcase
    slice_zero   = ~|y;
    slice_parity = ^y;
  end

endmodule

// File: rtl/alu_bitwise_seq.sv
// Multi-cycle bitwise logic unit: processes WIDTH-bit operands SLICE bits per cycle,
// LSB slice first, behind a valid/ready handshake, with incremental zero/parity flags.
module alu_bitwise_seq
  import alu_defs::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic             busy
);

  localparam int unsigned N  = WIDTH / SLICE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zero_q, zero_d, parity_q, parity_d;

  logic [SLICE-1:0] a_sl, b_sl, y_sl;
  logic             sl_zero, sl_parity;

  // Slice select by constant-index loop keeps every part-select static.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        a_sl = a_q[i*SLICE +: SLICE];
        b_sl = b_q[i*SLICE +: SLICE];
      end
    end
  end

  alu_bitwise_slice #(.SLICE(SLICE)) u_slice (
    .op           (op_q),
    .a            (a_sl),
    .b            (b_sl),
    .y            (y_sl),
    .slice_zero   (sl_zero),
    .slice_parity (sl_parity)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    parity_d = parity_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d      = A;
          b_d      = B;
          op_d     = op;
          result_d = '0;
          zero_d   = 1'b0;
          parity_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int unsigned i = 0; i < N; i++) begin
          if (cnt_q == CW'(i)) result_d[i*SLICE +: SLICE] = y_sl;
        end
        // First slice seeds the accumulators instead of folding into stale flags.
        zero_d   = (cnt_q == '0) ? sl_zero   : (zero_q & sl_zero);
        parity_d = (cnt_q == '0) ? sl_parity : (parity_q ^ sl_parity);
        if (cnt_q == CW'(N - 1)) state_d = ST_DONE;
        else                     cnt_d   = cnt_q + CW'(1);
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      parity_q <= parity_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    result    = result_q;
    zero      = zero_q;
    parity    = parity_q;
  end

endmodule
